// File: rtl/risc8_iobus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc8_iobus_pkg
//  Purpose  : Shared types and constants for the risc8 IO/data-bus fabric.
//  Revision : 1.0  initial release
// ============================================================================
package risc8_iobus_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   localparam logic [7:0] IO_FILL_UNMAPPED = 8'h00;
   localparam logic [7:0] IO_FILL_TIMEOUT  = 8'hFF;

   localparam int DEF_NSLOTS    = 4;
   localparam int DEF_IO_BITS   = 7;
   localparam int DEF_SLOT_BITS = 4;
   localparam int DEF_TIMEOUT   = 15;

endpackage
`default_nettype wire

// File: rtl/risc8_iobus_if.sv
`default_nettype none
// ============================================================================
//  Module   : risc8_iobus_if
//  Purpose  : Core data port, RAM steering and peripheral slot bus signals.
//  Revision : 1.0  initial release
// ============================================================================
interface risc8_iobus_if
   import risc8_iobus_pkg::*;
#(
   parameter int NSLOTS    = DEF_NSLOTS,
   parameter int SLOT_BITS = DEF_SLOT_BITS
);
   logic [15:0]           cpu_addr;
   logic                  cpu_ren;
   logic                  cpu_wen;
   logic [7:0]            cpu_wdata;
   logic [7:0]            cpu_rdata;
   logic                  cpu_stall;
   logic                  ram_wen;
   logic [7:0]            ram_rdata;
   logic [SLOT_BITS-1:0]  io_addr;
   logic [7:0]            io_wdata;
   logic [NSLOTS-1:0]     io_ren;
   logic [NSLOTS-1:0]     io_wen;
   logic [8*NSLOTS-1:0]   io_rdata;
   logic [NSLOTS-1:0]     io_ready;

   // Fabric side
   modport slave (
      input  cpu_addr, cpu_ren, cpu_wen, cpu_wdata, ram_rdata, io_rdata, io_ready,
      output cpu_rdata, cpu_stall, ram_wen, io_addr, io_wdata, io_ren, io_wen
   );

   // Core, RAM and peripheral side
   modport master (
      output cpu_addr, cpu_ren, cpu_wen, cpu_wdata, ram_rdata, io_rdata, io_ready,
      input  cpu_rdata, cpu_stall, ram_wen, io_addr, io_wdata, io_ren, io_wen
   );
endinterface
`default_nettype wire

// File: rtl/risc8_iobus_decode.sv
`default_nettype none
// ============================================================================
//  Module   : risc8_iobus_decode
//  Purpose  : IO window detect, slot mapping and one-hot slot strobes.
//  Revision : 1.0  initial release
// ============================================================================
module risc8_iobus_decode
   import risc8_iobus_pkg::*;
#(
   parameter int NSLOTS    = DEF_NSLOTS,
   parameter int IO_BITS   = DEF_IO_BITS,
   parameter int SLOT_BITS = DEF_SLOT_BITS
) (
   input  logic [15:SLOT_BITS] addr_i,
   input  logic                ren_i,
   input  logic                wen_i,
   output logic                io_win_o,
   output logic                mapped_o,
   output logic                rd_o,
   output logic                wr_o,
   output logic [NSLOTS-1:0]   ren_oh_o,
   output logic [NSLOTS-1:0]   wen_oh_o
);
   localparam int IDX_W = IO_BITS - SLOT_BITS;

   logic [IDX_W-1:0] slot;

   assign io_win_o = (addr_i[15:IO_BITS] == '0);
   assign slot     = addr_i[IO_BITS-1:SLOT_BITS];
   assign mapped_o = io_win_o && (32'(slot) < NSLOTS);

   // A simultaneous read and write is treated as a write only
   assign wr_o = wen_i;
   assign rd_o = ren_i & ~wen_i;

   for (genvar k = 0; k < NSLOTS; k++) begin : g_slot
      assign ren_oh_o[k] = mapped_o && rd_o && (slot == IDX_W'(k));
      assign wen_oh_o[k] = mapped_o && wr_o && (slot == IDX_W'(k));
   end
endmodule
`default_nettype wire

// File: rtl/risc8_iobus.sv
`default_nettype none
// ============================================================================
//  Module   : risc8_iobus
//  Purpose  : Core data-bus fabric: RAM steering, slot decode, wait states.
//             Define RISC8_IOBUS_TIMEOUT_EN to add the wait timeout/bus_err.
//  Revision : 1.0  initial release
// ============================================================================
module risc8_iobus
   import risc8_iobus_pkg::*;
#(
   parameter int NSLOTS    = DEF_NSLOTS,
   parameter int IO_BITS   = DEF_IO_BITS,
   parameter int SLOT_BITS = DEF_SLOT_BITS,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   risc8_iobus_if.slave  bus,
   input  logic          err_clr,
   output logic          bus_err
);
   logic                 dec_win, dec_mapped, dec_rd, dec_wr;
   logic [NSLOTS-1:0]    dec_ren_oh, dec_wen_oh;
   state_e               state_q, state_d;
   logic [NSLOTS-1:0]    oh_q, oh_d, act_oh;
   logic                 wr_q, wr_d;
   logic [SLOT_BITS-1:0] addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d, rdata_q, rdata_d, slot_rdata;
   logic                 resp_ram_q, resp_ram_d;
   logic                 idle, stall, ready_cur;

   risc8_iobus_decode #(
      .NSLOTS    (NSLOTS),
      .IO_BITS   (IO_BITS),
      .SLOT_BITS (SLOT_BITS)
   ) u_decode (
      .addr_i   (bus.cpu_addr[15:SLOT_BITS]),
      .ren_i    (bus.cpu_ren),
      .wen_i    (bus.cpu_wen),
      .io_win_o (dec_win),
      .mapped_o (dec_mapped),
      .rd_o     (dec_rd),
      .wr_o     (dec_wr),
      .ren_oh_o (dec_ren_oh),
      .wen_oh_o (dec_wen_oh)
   );

`ifdef RISC8_IOBUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, tmo;
`endif

   assign idle      = (state_q == IDLE);
   assign act_oh    = idle ? (dec_ren_oh | dec_wen_oh) : oh_q;
   assign ready_cur = |(bus.io_ready & act_oh);

   always_comb begin
      slot_rdata = '0;
      for (int k = 0; k < NSLOTS; k++)
         if (act_oh[k]) slot_rdata = slot_rdata | bus.io_rdata[8*k +: 8];
   end

   always_comb begin
      state_d    = state_q;
      oh_d       = oh_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      // Freeze the RAM word one cycle after a RAM read so cpu_rdata holds
      rdata_d    = resp_ram_q ? bus.ram_rdata : rdata_q;
      resp_ram_d = 1'b0;
      stall      = 1'b0;
`ifdef RISC8_IOBUS_TIMEOUT_EN
      cnt_d      = cnt_q;
      tmo        = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (dec_mapped && (dec_rd || dec_wr)) begin
               if (ready_cur) begin
                  if (dec_rd) rdata_d = slot_rdata;
               end else begin
                  state_d = WAIT;
                  stall   = 1'b1;
                  oh_d    = dec_ren_oh | dec_wen_oh;
                  wr_d    = dec_wr;
                  addr_d  = bus.cpu_addr[SLOT_BITS-1:0];
                  wdata_d = bus.cpu_wdata;
`ifdef RISC8_IOBUS_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end else if (dec_rd) begin
               if (dec_win) rdata_d    = IO_FILL_UNMAPPED;
               else         resp_ram_d = 1'b1;
            end
         end
         WAIT: begin
            if (ready_cur) begin
               state_d = IDLE;
               if (!wr_q) rdata_d = slot_rdata;
            end
`ifdef RISC8_IOBUS_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = IDLE;
               tmo     = 1'b1;
               if (!wr_q) rdata_d = IO_FILL_TIMEOUT;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
`else
            else stall = 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         oh_q       <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         resp_ram_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         oh_q       <= oh_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         resp_ram_q <= resp_ram_d;
      end
   end

`ifdef RISC8_IOBUS_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (tmo)          err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end
   assign bus_err = err_q;
`else
   logic unused_cfg;
   assign unused_cfg = err_clr ^ (TIMEOUT == 0);
   assign bus_err    = 1'b0;
`endif

   // Reset gates strobes and stall so an aborted access drops at once
   assign bus.io_ren    = {NSLOTS{reset}} & (idle ? dec_ren_oh : (oh_q & {NSLOTS{~wr_q}}));
   assign bus.io_wen    = {NSLOTS{reset}} & (idle ? dec_wen_oh : (oh_q & {NSLOTS{wr_q}}));
   assign bus.io_addr   = idle ? bus.cpu_addr[SLOT_BITS-1:0] : addr_q;
   assign bus.io_wdata  = idle ? bus.cpu_wdata : wdata_q;
   assign bus.cpu_stall = reset & stall;
   assign bus.ram_wen   = reset & idle & dec_wr & ~dec_win;
   assign bus.cpu_rdata = resp_ram_q ? bus.ram_rdata : rdata_q;
endmodule
`default_nettype wire
